// File: rtl/rv32i_seq_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer.
// Holds the state codes, the RV32I major opcodes, the PC-select codes,
// the control-output bundle and the opcode legality check.
package rv32i_seq_ctrl_pkg;

  // Codes 5 and 6 are never entered; the FSM treats them as a trap.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic PC_SEL_PLUS4 = 1'b0;
  localparam logic PC_SEL_ALU   = 1'b1;

  typedef struct packed {
    logic imem_req;
    logic ir_we;
    logic dec_en;
    logic pc_we;
    logic pc_sel;
    logic rf_we;
    logic dmem_req;
    logic dmem_we;
    logic retire;
    logic illegal;
  } ctl_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_seq_ctrl_if.sv
// Sequencer <-> datapath/memory bundle.
// master: the sequencer (takes IR fields, compare result and acks; drives
//         fetch/memory requests and datapath enables).
// slave : the datapath/memory side.
interface rv32i_seq_ctrl_if;
  logic [6:0] i_opcode;
  logic [2:0] i_f3;
  logic       i_cmp_taken;
  logic       i_imem_ack;
  logic       i_dmem_ack;
  logic       o_imem_req;
  logic       o_ir_we;
  logic       o_dec_en;
  logic       o_pc_we;
  logic       o_pc_sel;
  logic       o_rf_we;
  logic       o_dmem_req;
  logic       o_dmem_we;
  logic       o_retire;
  logic       o_illegal;
  logic [2:0] o_state;

  modport master (
    input  i_opcode, i_f3, i_cmp_taken, i_imem_ack, i_dmem_ack,
    output o_imem_req, o_ir_we, o_dec_en, o_pc_we, o_pc_sel, o_rf_we,
           o_dmem_req, o_dmem_we, o_retire, o_illegal, o_state
  );

  modport slave (
    output i_opcode, i_f3, i_cmp_taken, i_imem_ack, i_dmem_ack,
    input  o_imem_req, o_ir_we, o_dec_en, o_pc_we, o_pc_sel, o_rf_we,
           o_dmem_req, o_dmem_we, o_retire, o_illegal, o_state
  );
endinterface

// File: rtl/rv32i_seq_ctrl_mem_watchdog.sv
// mem_watchdog: counts cycles a memory request has waited without ack.
// Ports: clk, rst (sync, active high), i_clr (zero the count), i_en (a
// request is pending this cycle), i_ack (ack seen this cycle),
// o_expired (this is the TIMEOUT-th waiting cycle and no ack arrived).
module mem_watchdog #(
  parameter int W       = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_ack,
  output logic o_expired
);
  // cnt_q holds the waiting cycles before this one, so this cycle is the
  // TIMEOUT-th one when cnt_q == TIMEOUT-1. An ack in that cycle wins.
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)     cnt_d = '0;
    else if (i_en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_expired = i_en && !i_ack && (cnt_q == LIMIT);

endmodule

// File: rtl/rv32i_seq_ctrl.sv
// rv32i_seq_ctrl: multi-cycle RV32I sequencer.
// Steps FETCH -> DECODE -> EXEC -> [MEM] -> WB, driving IR/PC/RF/DMEM
// enables. All outputs are combinational from the state, the opcode
// latched in DECODE and the acks.
// Ports: clk, rst (sync, active high), bus (rv32i_seq_ctrl_if.master).
module rv32i_seq_ctrl
  import rv32i_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input logic               clk,
  input logic               rst,
  rv32i_seq_ctrl_if.master  bus
);

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;
  ctl_t       ctl;
  logic       ack, wd_en, wd_clr, wd_expired;

  // Only the ack belonging to the current wait state counts.
  assign wd_en = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ack   = (state_q == S_FETCH) ? bus.i_imem_ack :
                 (state_q == S_MEM)   ? bus.i_dmem_ack : 1'b0;

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH: begin
        ctl.imem_req = 1'b1;
        if (bus.i_imem_ack) begin
          ctl.ir_we = 1'b1;
          state_d   = S_DECODE;
        end else if (wd_expired) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        ctl.dec_en = 1'b1;
        op_d       = bus.i_opcode;
        state_d    = is_legal_op(bus.i_opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (op_q)
          OP_BRANCH: begin
            ctl.pc_we  = 1'b1;
            ctl.pc_sel = bus.i_cmp_taken;
            ctl.retire = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            ctl.rf_we  = 1'b1;
            ctl.pc_we  = 1'b1;
            ctl.pc_sel = PC_SEL_ALU;
            ctl.retire = 1'b1;
            state_d    = S_FETCH;
          end
          OP_FENCE: begin
            ctl.pc_we  = 1'b1;
            ctl.pc_sel = PC_SEL_PLUS4;
            ctl.retire = 1'b1;
            state_d    = S_FETCH;
          end
          OP_LOAD, OP_STORE:              state_d = S_MEM;
          OP_OP, OP_IMM, OP_LUI, OP_AUIPC: state_d = S_WB;
          default:                        state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        ctl.dmem_req = 1'b1;
        ctl.dmem_we  = (op_q == OP_STORE);
        if (bus.i_dmem_ack) begin
          if (op_q == OP_STORE) begin
            ctl.pc_we  = 1'b1;
            ctl.pc_sel = PC_SEL_PLUS4;
            ctl.retire = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_expired) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        ctl.rf_we  = 1'b1;
        ctl.pc_we  = 1'b1;
        ctl.pc_sel = PC_SEL_PLUS4;
        ctl.retire = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  ctl.illegal = 1'b1;
      default: state_d = S_TRAP;
    endcase
    // Reset silences every output in the cycle it is applied.
    if (rst) begin
      ctl     = '0;
      state_d = S_FETCH;
      op_d    = '0;
    end
  end

  // Restart the wait count on every state change, ack or idle cycle.
  assign wd_clr = rst || ack || !wd_en || (state_d != state_q);

  mem_watchdog #(
    .W       (TIMEOUT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (wd_clr),
    .i_en      (wd_en),
    .i_ack     (ack),
    .o_expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign bus.o_imem_req = ctl.imem_req;
  assign bus.o_ir_we    = ctl.ir_we;
  assign bus.o_dec_en   = ctl.dec_en;
  assign bus.o_pc_we    = ctl.pc_we;
  assign bus.o_pc_sel   = ctl.pc_sel;
  assign bus.o_rf_we    = ctl.rf_we;
  assign bus.o_dmem_req = ctl.dmem_req;
  assign bus.o_dmem_we  = ctl.dmem_we;
  assign bus.o_retire   = ctl.retire;
  assign bus.o_illegal  = ctl.illegal;
  assign bus.o_state    = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// Self-checking bench for rv32i_seq_ctrl. Each scenario pushes per-cycle
// stimulus together with the expected state/outputs into a scoreboard
// queue, then drives each entry and compares the DUT against it.
module tb_rv32i_seq_ctrl;
  import rv32i_seq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_seq_ctrl_if bus();

  rv32i_seq_ctrl #(.TIMEOUT_W(8), .TIMEOUT(200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected flag masks, ordered as in obs().
  localparam logic [9:0] IMR = 10'h200, IRW = 10'h100, DEC = 10'h080,
                         PCW = 10'h040, PCS = 10'h020, RFW = 10'h010,
                         DRQ = 10'h008, DWE = 10'h004, RET = 10'h002,
                         ILL = 10'h001, NONE = 10'h000;

  typedef struct {
    string       tag;
    logic        r, ia, da, cmp;
    logic [6:0]  op;
    logic [12:0] exp;
  } stim_t;

  stim_t sq[$];
  int checks   = 0;
  int failures = 0;

  function automatic void push(input string tag, input logic r, input logic ia,
                               input logic da, input logic cmp, input logic [6:0] op,
                               input logic [2:0] st, input logic [9:0] f);
    stim_t s;
    s.tag = tag; s.r = r; s.ia = ia; s.da = da; s.cmp = cmp; s.op = op;
    s.exp = {st, f};
    sq.push_back(s);
  endfunction

  // FETCH with immediate ack followed by DECODE of op.
  function automatic void fetch_dec(input string tag, input logic [6:0] op);
    push({tag, "_fetch"}, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 3'd0, IMR | IRW);
    push({tag, "_dec"},   1'b0, 1'b0, 1'b0, 1'b0, op,    3'd1, DEC);
  endfunction

  function automatic logic [12:0] obs();
    return {bus.o_state, bus.o_imem_req, bus.o_ir_we, bus.o_dec_en, bus.o_pc_we,
            bus.o_pc_sel, bus.o_rf_we, bus.o_dmem_req, bus.o_dmem_we,
            bus.o_retire, bus.o_illegal};
  endfunction

  task automatic drive(input stim_t s);
    rst             = s.r;
    bus.i_imem_ack  = s.ia;
    bus.i_dmem_ack  = s.da;
    bus.i_cmp_taken = s.cmp;
    bus.i_opcode    = s.op;
    bus.i_f3        = 3'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    stim_t s; logic [12:0] got;
    push("rst0", 1'b1, 1'b1, 1'b1, 1'b1, OP_OP, 3'd0, NONE);
    push("rst1", 1'b1, 1'b1, 1'b1, 1'b0, OP_OP, 3'd0, NONE);
    push("rst_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, IMR);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s); @(negedge clk); got = obs(); checks++;
      if (got !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, got, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    stim_t s; logic [12:0] got;
    fetch_dec("addi", OP_IMM);
    push("addi_exec", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, NONE);
    push("addi_wb",   1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd4, RFW | PCW | RET);
    // Stray acks outside FETCH/MEM must change nothing.
    push("lui_fetch", 1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 3'd0, IMR | IRW);
    push("lui_dec",   1'b0, 1'b1, 1'b1, 1'b0, OP_LUI, 3'd1, DEC);
    push("lui_exec",  1'b0, 1'b1, 1'b1, 1'b1, 7'h00, 3'd2, NONE);
    push("lui_wb",    1'b0, 1'b1, 1'b1, 1'b1, 7'h00, 3'd4, RFW | PCW | RET);
    fetch_dec("auipc", OP_AUIPC);
    push("auipc_exec", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, NONE);
    push("auipc_wb",   1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd4, RFW | PCW | RET);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s); @(negedge clk); got = obs(); checks++;
      if (got !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, got, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    stim_t s; logic [12:0] got;
    fetch_dec("beq_t", OP_BRANCH);
    push("beq_t_exec", 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 3'd2, PCW | PCS | RET);
    fetch_dec("beq_n", OP_BRANCH);
    push("beq_n_exec", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, PCW | RET);
    fetch_dec("jal", OP_JAL);
    push("jal_exec",  1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, RFW | PCW | PCS | RET);
    fetch_dec("jalr", OP_JALR);
    push("jalr_exec", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, RFW | PCW | PCS | RET);
    fetch_dec("fence", OP_FENCE);
    push("fence_exec", 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 3'd2, PCW | RET);
    push("after_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, IMR);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s); @(negedge clk); got = obs(); checks++;
      if (got !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, got, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem();
    stim_t s; logic [12:0] got;
    fetch_dec("lw", OP_LOAD);
    push("lw_exec", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, NONE);
    for (int i = 0; i < 5; i++)
      // An imem ack while waiting on data memory is not a data ack.
      push("lw_wait", 1'b0, (i == 2), 1'b0, 1'b0, 7'h00, 3'd3, DRQ);
    push("lw_ack", 1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 3'd3, DRQ);
    push("lw_wb",  1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd4, RFW | PCW | RET);
    fetch_dec("sw", OP_STORE);
    push("sw_exec", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, NONE);
    push("sw_wait", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd3, DRQ | DWE);
    push("sw_ack",  1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 3'd3, DRQ | DWE | PCW | RET);
    push("sw_next", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, IMR);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s); @(negedge clk); got = obs(); checks++;
      if (got !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, got, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    stim_t s; logic [12:0] got;
    fetch_dec("ecall", 7'b1110011);
    for (int i = 0; i < 20; i++)
      push("trap_hold", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), OP_LOAD, 3'd7, ILL);
    push("trap_rst",   1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, NONE);
    push("trap_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, IMR);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s); @(negedge clk); got = obs(); checks++;
      if (got !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, got, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t s; logic [12:0] got;
    push("to_rst", 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, NONE);
    for (int i = 1; i <= 200; i++)
      push("to_fetch_wait", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, IMR);
    push("to_fetch_trap", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd7, ILL);
    push("to_rst2", 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, NONE);
    for (int i = 1; i < 200; i++)
      push("to_fetch_wait2", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, IMR);
    push("to_ack_last", 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 3'd0, IMR | IRW);
    push("to_dec",  1'b0, 1'b0, 1'b0, 1'b0, OP_OP, 3'd1, DEC);
    push("to_exec", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, NONE);
    push("to_wb",   1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd4, RFW | PCW | RET);
    fetch_dec("to_sw", OP_STORE);
    push("to_sw_exec", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, NONE);
    for (int i = 1; i <= 200; i++)
      push("to_mem_wait", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd3, DRQ | DWE);
    push("to_mem_trap", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd7, ILL);
    push("to_rst3", 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, NONE);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s); @(negedge clk); got = obs(); checks++;
      if (got !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, got, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_mid_mem();
    stim_t s; logic [12:0] got;
    fetch_dec("rsw", OP_STORE);
    push("rsw_exec", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, NONE);
    push("rsw_wait", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd3, DRQ | DWE);
    push("rsw_rst",  1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 3'd0, NONE);
    push("rsw_after", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, IMR);
    fetch_dec("add", OP_OP);
    push("add_exec", 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd2, NONE);
    push("add_wb",   1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd4, RFW | PCW | RET);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s); @(negedge clk); got = obs(); checks++;
      if (got !== s.exp) begin failures++; $display("FAIL %s got=%h exp=%h", s.tag, got, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_imem_ack = 1'b0; bus.i_dmem_ack = 1'b0; bus.i_cmp_taken = 1'b0;
    bus.i_opcode = 7'h00; bus.i_f3 = 3'd0;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_branch_jump();
    test_mem();
    test_illegal();
    test_timeout();
    test_rst_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit reached without completion");
    $fatal(1);
  end

endmodule
